// File: rtl/shift_add_mul_seq.sv
// Sequential W x W unsigned multiplier: one partial product per cycle through a shared 2W-bit CLA.
// Optional SHIFT_ADD_MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are zero.
module shift_add_mul_cla #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N-1:0] g, pr;
    logic [N:0]   c;
    logic         gg, gp, cb;

    assign g  = x & y;
    assign pr = x ^ y;

    // 4-bit groups: carries ripple inside a group, group carries come from group G/P
    always_comb begin
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        gp   = 1'b1;
        cb   = cin;
        for (int k = 0; k < N; k += 4) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = k; j < N && j < k + 4; j++) begin
                c[j+1] = g[j] | (pr[j] & c[j]);
                gg     = g[j] | (pr[j] & gg);
                gp     = gp & pr[j];
            end
            cb = gg | (gp & cb);
            c[(k + 4 < N) ? k + 4 : N] = cb;
        end
    end

    assign s    = pr ^ c[N-1:0];
    assign cout = c[N];
endmodule

module shift_add_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [2*W-1:0] acc, mcand, addend, sum, p_q;
    logic [W-1:0]   mplr;
    logic [CW-1:0]  cnt;
    logic           last;
    logic           cla_cout_unused;

    assign addend = mplr[0] ? mcand : '0;

    shift_add_mul_cla #(.N(2*W)) u_cla (
        .x    (acc),
        .y    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cla_cout_unused)
    );

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    assign last = (cnt == CW'(W-1)) || (mplr[W-1:1] == '0);
`else
    assign last = (cnt == CW'(W-1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            p_q   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc   <= '0;
                    mcand <= {{W{1'b0}}, a};
                    mplr  <= b;
                    cnt   <= '0;
                end
                RUN: begin
                    acc   <= sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    // product register only moves on the final accumulate, so no partial value leaks out
                    if (last) p_q <= sum;
                end
                default: ;
            endcase
        end
    end

    assign p = p_q;
endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Directed bench for shift_add_mul_seq (W=8); expected latencies follow SHIFT_ADD_MUL_EARLY_TERM_EN.
module tb_shift_add_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] p;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    shift_add_mul_seq #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // RUN cycles expected for a given multiplier
    function automatic int run_len(input logic [7:0] mb);
        int h;
        h = 0;
        for (int i = 0; i < 8; i++) if (mb[i]) h = i + 1;
        if (!ET) return 8;
        return (h < 1) ? 1 : h;
    endfunction

    // Accept one pair, measure edges to out_valid, check product, hold for 'hold' cycles, then handshake.
    task automatic run_mul(input string tag, input logic [7:0] xa, input logic [7:0] xb, input int hold);
        int n;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = xa; b = xb; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(run_len(xb)));
        chk({tag, " p"}, 32'(p), 32'(xa) * 32'(xb));
        for (int h = 0; h < hold; h++) tick();
        out_ready = 1'b1;
        tick();
        chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n, low;
        logic [7:0] ra, rb;

        // reset state
        tick();
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst p", 32'(p), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic 13*11 with out_ready held high
        in_valid = 1'b1; a = 8'd13; b = 8'd11; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("basic busy", 32'(busy), 32'd1);
        n = 0; low = 0;
        while (!out_valid && n < 40) begin
            if (!in_ready) low++;
            tick();
            n++;
        end
        chk("basic latency", 32'(n), 32'(run_len(8'd11)));
        chk("basic p", 32'(p), 32'h008F);
        if (!in_ready) low++;
        tick();
        // in_ready stays low for every RUN cycle plus the DONE cycle
        chk("basic in_ready low", 32'(low), 32'(run_len(8'd11) + 1));
        chk("basic idle in_ready", 32'(in_ready), 32'd1);
        chk("basic idle busy", 32'(busy), 32'd0);

        // extremes
        run_mul("max", 8'd255, 8'd255, 0);
        chk("max p hex", 32'(p), 32'hFE01);
        run_mul("zero a", 8'd0, 8'd200, 0);
        run_mul("one", 8'd1, 8'd1, 0);

        // back-pressure with ignored in_valid pulses
        in_valid = 1'b1; a = 8'd100; b = 8'd3; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp latency", 32'(n), 32'(run_len(8'd3)));
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; a = 8'd9; b = 8'd9;
            tick();
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold p", 32'(p), 32'd300);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp handshake", 32'(out_valid), 32'd0);
        chk("bp idle", 32'(in_ready), 32'd1);
        chk("bp p kept", 32'(p), 32'd300);
        tick();
        chk("bp no extra", 32'(busy), 32'd0);

        // early-termination-sensitive vectors
        run_mul("b1", 8'd200, 8'd1, 0);
        run_mul("b80", 8'd2, 8'h80, 0);
        run_mul("b0", 8'd77, 8'd0, 0);

        // mid-operation reset in RUN cycle 4
        in_valid = 1'b1; a = 8'd7; b = 8'd9; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort p", 32'(p), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_mul("after abort", 8'd3, 8'd5, 0);

        // random pairs with random output stalls
        for (int t = 0; t < 200; t++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_mul("rand", ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
